// File: rtl/calc_pkg.sv
// Shared constants, key opcodes and FSM states for the keypad calculator controller.
package calc_pkg;
  localparam int DIGITS_DEF = 4;
  localparam int OPW_DEF    = 14;
  localparam int RESW_DEF   = 28;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_DIV = 2'd3;

  typedef enum logic [2:0] {
    ENTER_A, ENTER_B, EXEC, SHOW, ERROR
  } calc_state_e;
endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand register with digit counter: clear, direct load, or shift in one digit.
module calc_digit_accum #(
  parameter int DIGITS = 4,
  parameter int OPW    = 14,
  parameter int CNTW   = $clog2(DIGITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [OPW-1:0]  load_val,
  input  logic [CNTW-1:0] load_cnt,
  input  logic            acc,
  input  logic [3:0]      digit,
  output logic [OPW-1:0]  val,
  output logic [CNTW-1:0] cnt
);
  logic [OPW-1:0]  val_q, val_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr) begin
      val_d = '0;
      cnt_d = '0;
    end else if (load) begin
      val_d = load_val;
      cnt_d = load_cnt;
    end else if (acc && digit <= 4'd9 && cnt_q < CNTW'(DIGITS)) begin
      val_d = val_q * OPW'(10) + OPW'(digit);
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val = val_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/calc_control.sv
// Keypad calculator sequencer: builds A/op/B from key events, runs the ALU handshake,
// latches the result and selects the displayed value.
module calc_control
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int OPW    = OPW_DEF,
  parameter int RESW   = RESW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic                   key_is_num,
  input  logic [3:0]             key_digit,
  input  logic [2:0]             key_op,
  output logic                   alu_start,
  output logic [OPW-1:0]         alu_a,
  output logic [OPW-1:0]         alu_b,
  output logic [1:0]             alu_op,
  input  logic                   alu_done,
  input  logic [RESW-1:0]        alu_result,
  output logic signed [RESW-1:0] display_value,
  output logic                   error,
  output logic                   busy
);
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam logic [RESW-1:0] MAXV = RESW'(10**DIGITS - 1);

  calc_state_e     state_q, state_d;
  logic [1:0]      op_q, op_d, nop_q, nop_d;
  logic            chain_q, chain_d, start_q, start_d;
  logic [RESW-1:0] res_q, res_d;

  logic            a_clr, a_load, a_acc, b_clr, b_acc;
  logic [OPW-1:0]  a_load_val, a_val, b_val;
  logic [CNTW-1:0] a_load_cnt, a_cnt, b_cnt;

  logic       is_digit, is_arith, is_eq, is_clr, go_exec, res_ok;
  logic [1:0] chain_op;

  calc_digit_accum #(.DIGITS(DIGITS), .OPW(OPW), .CNTW(CNTW)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .load_cnt(a_load_cnt), .acc(a_acc), .digit(key_digit), .val(a_val), .cnt(a_cnt)
  );

  calc_digit_accum #(.DIGITS(DIGITS), .OPW(OPW), .CNTW(CNTW)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(1'b0), .load_val('0),
    .load_cnt('0), .acc(b_acc), .digit(key_digit), .val(b_val), .cnt(b_cnt)
  );

  assign is_digit = key_valid && key_is_num;
  assign is_arith = key_valid && !key_is_num && key_op <= OP_DIV;
  assign is_eq    = key_valid && !key_is_num && key_op == OP_EQ;
  assign is_clr   = key_valid && !key_is_num && key_op == OP_CLR;
  assign res_ok   = !res_q[RESW-1] && res_q <= MAXV;
  // A fused op from ENTER_B takes precedence over whatever key lands in SHOW.
  assign chain_op = chain_q ? nop_q : key_op[1:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nop_d      = nop_q;
    chain_d    = chain_q;
    res_d      = res_q;
    start_d    = 1'b0;
    go_exec    = 1'b0;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    a_acc      = 1'b0;
    b_clr      = 1'b0;
    b_acc      = 1'b0;
    if (is_clr) begin
      state_d = ENTER_A;
      a_clr   = 1'b1;
      b_clr   = 1'b1;
      op_d    = ALU_ADD;
      nop_d   = ALU_ADD;
      chain_d = 1'b0;
      res_d   = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (is_digit) a_acc = 1'b1;
          else if (is_arith) begin
            op_d    = key_op[1:0];
            b_clr   = 1'b1;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit) b_acc = 1'b1;
          else if (is_arith) begin
            if (b_cnt == '0) op_d = key_op[1:0];
            else begin
              nop_d   = key_op[1:0];
              chain_d = 1'b1;
              go_exec = 1'b1;
            end
          end else if (is_eq && b_cnt != '0) go_exec = 1'b1;
          if (go_exec) begin
            state_d = EXEC;
            start_d = !(op_q == ALU_DIV && b_val == '0);
          end
        end
        EXEC: begin
          if (op_q == ALU_DIV && b_val == '0) state_d = ERROR;
          else if (alu_done) begin
            res_d   = alu_result;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (chain_q || is_arith) begin
            chain_d = 1'b0;
            if (res_ok) begin
              a_load     = 1'b1;
              a_load_val = res_q[OPW-1:0];
              a_load_cnt = CNTW'(DIGITS);
              op_d       = chain_op;
              b_clr      = 1'b1;
              state_d    = ENTER_B;
            end else state_d = ERROR;
          end else if (is_digit && key_digit <= 4'd9) begin
            a_load     = 1'b1;
            a_load_val = OPW'(key_digit);
            a_load_cnt = CNTW'(1);
            state_d    = ENTER_A;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTER_A;
      op_q    <= ALU_ADD;
      nop_q   <= ALU_ADD;
      chain_q <= 1'b0;
      start_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      nop_q   <= nop_d;
      chain_q <= chain_d;
      start_q <= start_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_A: display_value = RESW'(a_val);
      ENTER_B: display_value = (b_cnt != '0) ? RESW'(b_val) : RESW'(a_val);
      EXEC:    display_value = RESW'(b_val);
      SHOW:    display_value = res_q;
      default: display_value = '0;
    endcase
  end

  assign alu_start = start_q;
  assign alu_a     = a_val;
  assign alu_b     = b_val;
  assign alu_op    = op_q;
  assign error     = (state_q == ERROR);
  assign busy      = (state_q == EXEC);
endmodule

// File: tb/tb_calc_control.sv
// Directed bench for calc_control: key sequences with a hand-driven ALU responder.
module tb_calc_control;
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                key_valid = 1'b0, key_is_num = 1'b0;
  logic [3:0]          key_digit = '0;
  logic [2:0]          key_op = '0;
  logic                alu_start, alu_done = 1'b0, error, busy;
  logic [13:0]         alu_a, alu_b;
  logic [1:0]          alu_op;
  logic [27:0]         alu_result = '0;
  logic signed [27:0]  display_value;
  int n_cmp = 0, n_bad = 0, n_start = 0, s0;

  calc_control dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_is_num(key_is_num),
    .key_digit(key_digit), .key_op(key_op), .alu_start(alu_start), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result),
    .display_value(display_value), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (alu_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic key(input logic num, input logic [3:0] d, input logic [2:0] op);
    @(negedge clk);
    key_valid = 1'b1; key_is_num = num; key_digit = d; key_op = op;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);  key(1'b1, d, 3'd0); endtask
  task automatic opk(input logic [2:0] o);  key(1'b0, 4'd0, o); endtask

  task automatic run_alu(input string tag, input int res, input int ea, input int eb,
                         input int eop, input bit with_key);
    int i = 0;
    while (!alu_start && i < 10) begin @(negedge clk); i++; end
    chk({tag, "_start"}, 32'(alu_start), 32'd1);
    chk({tag, "_a"}, 32'(alu_a), 32'(ea));
    chk({tag, "_b"}, 32'(alu_b), 32'(eb));
    chk({tag, "_op"}, 32'(alu_op), 32'(eop));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_start1"}, 32'(alu_start), 32'd0);
    alu_done = 1'b1; alu_result = 28'(res);
    if (with_key) begin key_valid = 1'b1; key_is_num = 1'b1; key_digit = 4'd7; end
    @(negedge clk);
    alu_done = 1'b0; key_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_disp", 32'(display_value), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(alu_start), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1: 12 + 34 = 46
    dig(1); dig(2);
    chk("t1_a12", 32'(display_value), 32'd12);
    dig(4'd12);
    chk("t1_dig_gt9", 32'(display_value), 32'd12);
    opk(3'd4);
    chk("t1_eq_in_a", 32'(display_value), 32'd12);
    opk(3'd0);
    chk("t1_b_empty", 32'(display_value), 32'd12);
    dig(3); dig(4);
    chk("t1_b34", 32'(display_value), 32'd34);
    s0 = n_start;
    opk(3'd4);
    run_alu("t1", 46, 12, 34, 0, 1'b0);
    chk("t1_disp", 32'(display_value), 32'd46);
    chk("t1_busy0", 32'(busy), 32'd0);
    chk("t1_nstart", 32'(n_start - s0), 32'd1);

    // 2: fifth digit ignored, 9999*9999, then overflow chain -> ERROR
    opk(3'd5);
    repeat (5) dig(9);
    chk("t2_a9999", 32'(display_value), 32'd9999);
    opk(3'd2);
    repeat (4) dig(9);
    opk(3'd4);
    run_alu("t2", 99980001, 9999, 9999, 2, 1'b0);
    chk("t2_disp", 32'(display_value), 32'd99980001);
    opk(3'd0);
    chk("t2_err", 32'(error), 32'd1);
    chk("t2_disp0", 32'(display_value), 32'd0);
    dig(5);
    chk("t2_err_sticky", 32'(error), 32'd1);

    // 3: 7 / 0 -> ERROR without starting the ALU
    opk(3'd5);
    chk("t3_clr_err", 32'(error), 32'd0);
    s0 = n_start;
    dig(7); opk(3'd3); dig(0); opk(3'd4);
    chk("t3_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t3_err", 32'(error), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_nostart", 32'(n_start - s0), 32'd0);
    opk(3'd5);
    chk("t3_clr_err2", 32'(error), 32'd0);
    chk("t3_clr_disp", 32'(display_value), 32'd0);
    dig(3);
    chk("t3_a_fresh", 32'(display_value), 32'd3);

    // 4: 5 - 8 = -3, negative result cannot chain
    opk(3'd5);
    dig(5); opk(3'd1); dig(8); opk(3'd4);
    run_alu("t4", -3, 5, 8, 1, 1'b0);
    chk("t4_neg", 32'(display_value), 32'hFFFF_FFFD);
    key(1'b0, 4'd0, 3'd6);
    chk("t4_op6_ign", 32'(error), 32'd0);
    opk(3'd0);
    chk("t4_err", 32'(error), 32'd1);

    // 5: CLR aborts EXEC; late alu_done ignored
    opk(3'd5);
    dig(2); opk(3'd0); dig(3); opk(3'd4);
    chk("t5_busy", 32'(busy), 32'd1);
    opk(3'd5);
    chk("t5_busy0", 32'(busy), 32'd0);
    alu_done = 1'b1; alu_result = 28'd5;
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
    chk("t5_disp0", 32'(display_value), 32'd0);
    chk("t5_err0", 32'(error), 32'd0);

    // 6: op replaced; alu_done beats a same-cycle digit
    dig(2); opk(3'd0); opk(3'd1); dig(4); opk(3'd4);
    run_alu("t6", -2, 2, 4, 1, 1'b1);
    chk("t6_show", 32'(display_value), 32'hFFFF_FFFE);
    chk("t6_busy0", 32'(busy), 32'd0);
    dig(6);
    chk("t6_newa", 32'(display_value), 32'd6);

    // 7: 2 + 3 + 1 = chains the fused op onto the result
    opk(3'd5);
    dig(2); opk(3'd0); dig(3); opk(3'd0);
    run_alu("t7a", 5, 2, 3, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("t7_chain_a", 32'(display_value), 32'd5);
    dig(1); opk(3'd4);
    run_alu("t7b", 6, 5, 1, 0, 1'b0);
    chk("t7_disp", 32'(display_value), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_control.md
Name: calc_control

Overview:
Sequencing controller for the keypad calculator. It consumes validated key events from the decode chain (digit or operator), builds operand A, the pending operator and operand B, and launches the arithmetic unit through a start/done handshake. It latches the result and drives the value shown on the display. It sits between the key-decode path and the ALU/display blocks.

Parameters:
DIGITS, 4, maximum decimal digits per operand
OPW, 14, operand width in bits, must hold 10^DIGITS-1
RESW, 28, signed result width from the ALU

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_valid  in  1  one-cycle pulse: new key event
key_is_num  in  1  1 = digit key, 0 = operator key
key_digit  in  4  digit value 0-9, valid with key_is_num
key_op  in  3  operator code, valid when key_is_num=0
alu_start  out  1  one-cycle pulse launching the ALU
alu_a  out  OPW  operand A
alu_b  out  OPW  operand B
alu_op  out  2  ALU operation: add, sub, mul, div
alu_done  in  1  one-cycle pulse: result valid
alu_result  in  RESW  signed result, valid with alu_done
display_value  out  RESW  signed value for display
error  out  1  sticky error flag
busy  out  1  high while in EXEC

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state = ENTER_A
  - A = B = 0, pending op = ADD, digit counts = 0
  - alu_start = 0, display_value = 0, error = 0, busy = 0
- Operator codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 EQ, 5 CLR. Codes 6 and 7 are ignored.
- Digit accumulation: operand <= operand*10 + digit, done in OPW bits.
  - A digit is ignored once the count reaches DIGITS.
  - A digit > 9 is ignored.
- All updates are registered. A key event with key_valid in cycle n is visible at n+1.
- State ENTER_A:
  - Digit: accumulate into A.
  - ADD/SUB/MUL/DIV: latch the pending op, clear B and its digit count, go to ENTER_B.
  - EQ: no operation.
  - display_value = A, zero-extended.
- State ENTER_B:
  - Digit: accumulate into B.
  - Arithmetic op with zero B digits: replaces the pending op.
  - Arithmetic op with at least one B digit: treated as EQ.
  - EQ with at least one B digit: go to EXEC.
  - EQ with zero B digits: ignored.
  - display_value = B if at least one B digit has been entered, else A.
- State EXEC:
  - Divide by zero: if the pending op is DIV and B = 0, do not assert alu_start; go to ERROR next cycle.
  - Otherwise alu_start = 1 for exactly one cycle, the first cycle in EXEC.
  - alu_a, alu_b and alu_op stay stable from entry until alu_done.
  - busy = 1 throughout EXEC.
  - All key events are ignored except CLR.
  - On alu_done: latch alu_result and go to SHOW next cycle.
  - alu_done outside EXEC is ignored.
- State SHOW:
  - display_value = latched result.
  - Digit: reset A to that digit (count 1), go to ENTER_A.
  - Arithmetic op, result in 0..10^DIGITS-1: A <= result, latch the op, go to ENTER_B (chaining).
  - Arithmetic op, result outside that range: go to ERROR.
  - EQ: ignored.
- State ERROR:
  - error = 1, display_value = 0.
  - Only CLR is accepted.
- CLR in any state:
  - Return to ENTER_A with all registers at reset values and error = 0.
  - CLR during EXEC aborts: busy drops next cycle, and a later alu_done is ignored.
- Chained op fused with EQ: an op key in ENTER_B with B digits present goes to EXEC. The op that was pressed is stored as the next pending op and is applied in SHOW when execution completes, so "2+3+" behaves as chaining.
- key_valid and alu_done in the same cycle during EXEC: alu_done wins, unless the key is CLR.

Decomposition:
- Package calc_pkg holds:
  - opcode localparams (ADD…CLR)
  - state enum: ENTER_A, ENTER_B, EXEC, SHOW, ERROR
  - DIGITS, OPW and RESW defaults
- One sub-module, calc_digit_accum: operand register plus digit counter, with load, clear and accumulate controls. It is instantiated twice, for A and B.

Test Plan:
1. Keys 1,2,+,3,4,= with ALU returning 46 two cycles after start:
   - exactly one alu_start pulse
   - alu_a = 12, alu_b = 34, alu_op = ADD
   - display_value = 46 in SHOW
2. Keys 9,9,9,9,9:
   - A = 9999, fifth digit ignored
   - then *, 9,9,9,9, = with result 99980001 → display 99980001
   - then + → ERROR, error = 1
3. Keys 7, /, 0, =:
   - no alu_start
   - ERROR with error = 1
   - CLR → ENTER_A, A = 0, error = 0
4. Keys 5,-,8,= with ALU returning −3:
   - display_value = −3 (two's complement)
   - then + → ERROR, since −3 cannot chain
5. Keys 2,+,3,= then CLR on the cycle before alu_done:
   - busy falls
   - the later alu_done is ignored; display_value stays 0
6. Keys 2,+,-,4,=:
   - op is replaced, so alu_op = SUB
   - alu_done and a digit key arrive in the same cycle: the digit is ignored and SHOW is entered
